// File: rtl/serial_magnitude_comparator_pkg.sv
// Shared types for the serial magnitude comparator: FSM states and the
// one-hot result encoding.
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef logic [2:0] res_t;

    localparam int unsigned RES_LT = 0;
    localparam int unsigned RES_EQ = 1;
    localparam int unsigned RES_GT = 2;

endpackage

// File: rtl/serial_magnitude_comparator_digit_compare.sv
// Combinational unsigned compare of two DIGIT-bit values; a generalisation
// of the original 2-bit compare logic.
module digit_compare #(
    parameter int unsigned DIGIT = 1
) (
    input  logic [DIGIT-1:0] a_i,
    input  logic [DIGIT-1:0] b_i,
    output logic             gt_o,
    output logic             eq_o,
    output logic             lt_o
);

    always_comb begin
        gt_o = (a_i > b_i);
        eq_o = (a_i == b_i);
        lt_o = (a_i < b_i);
    end

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Serial MSB-first magnitude comparator, DIGIT bits per clock with early
// termination; unsigned or two's-complement, valid/ready on both sides.
module serial_magnitude_comparator
    import cmp_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1,
    parameter int unsigned CW    = $clog2(WIDTH / DIGIT + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             signed_mode,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             gt,
    output logic             eq,
    output logic             lt,
    output logic [CW-1:0]    digits
);

    localparam int unsigned    NDIG = WIDTH / DIGIT;
    localparam logic [CW-1:0]  LAST = CW'(NDIG);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sx_q, sx_d;
    logic [WIDTH-1:0] sy_q, sy_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    cnt_inc;
    res_t             res_q, res_d;
    logic             rdy_q;
    logic [WIDTH-1:0] msb_flip;
    logic             dig_gt, dig_eq, dig_lt;

    digit_compare #(.DIGIT(DIGIT)) u_digit_compare (
        .a_i  (sx_q[WIDTH-1 -: DIGIT]),
        .b_i  (sy_q[WIDTH-1 -: DIGIT]),
        .gt_o (dig_gt),
        .eq_o (dig_eq),
        .lt_o (dig_lt)
    );

    // Inverting both MSBs maps two's complement onto offset binary, so RUN
    // needs no knowledge of the mode.
    assign msb_flip = {signed_mode, {(WIDTH-1){1'b0}}};
    assign cnt_inc  = cnt_q + CW'(1);

    assign in_ready  = rdy_q && (state_q == IDLE);
    assign res_valid = (state_q == DONE);
    assign gt        = res_q[RES_GT];
    assign eq        = res_q[RES_EQ];
    assign lt        = res_q[RES_LT];
    assign digits    = cnt_q;

    always_comb begin
        state_d = state_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    sx_d    = x ^ msb_flip;
                    sy_d    = y ^ msb_flip;
                    cnt_d   = '0;
                    res_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                cnt_d = cnt_inc;
                if (dig_gt) begin
                    res_d         = '0;
                    res_d[RES_GT] = 1'b1;
                    state_d       = DONE;
                end else if (dig_lt) begin
                    res_d         = '0;
                    res_d[RES_LT] = 1'b1;
                    state_d       = DONE;
                end else if (dig_eq && (cnt_inc == LAST)) begin
                    res_d         = '0;
                    res_d[RES_EQ] = 1'b1;
                    state_d       = DONE;
                end else begin
                    sx_d = sx_q << DIGIT;
                    sy_d = sy_q << DIGIT;
                end
            end
            DONE: begin
                if (res_ready) begin
                    res_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                res_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sx_q    <= '0;
            sy_q    <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            rdy_q   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Self-checking bench: three comparator configurations (8/1, 8/2, 2/1) driven
// from a vector table, an exhaustive 2-bit sweep and multi-cycle corner cases.
module tb_serial_magnitude_comparator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       res_ready = 1'b0;
    logic       sm = 1'b0;
    logic [7:0] xs = '0;
    logic [7:0] ys = '0;
    int         sel = 0;

    logic       ir_a, rv_a, gt_a, eq_a, lt_a;
    logic       ir_b, rv_b, gt_b, eq_b, lt_b;
    logic       ir_c, rv_c, gt_c, eq_c, lt_c;
    logic [3:0] dg_a;
    logic [2:0] dg_b;
    logic [1:0] dg_c;

    logic       cur_ir, cur_rv;
    logic [2:0] cur_f;
    logic [3:0] cur_dg;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [2:0] flags;
        int         digits;
        int         lat;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        int         sel;
        logic [7:0] x;
        logic [7:0] y;
        logic       sm;
        logic [2:0] flags;
        int         digits;
    } vec_t;
    vec_t vecs[10];

    always #5 clk = ~clk;

    serial_magnitude_comparator #(.WIDTH(8), .DIGIT(1)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 0), .in_ready(ir_a),
        .x(xs), .y(ys), .signed_mode(sm), .res_valid(rv_a), .res_ready(res_ready),
        .gt(gt_a), .eq(eq_a), .lt(lt_a), .digits(dg_a)
    );

    serial_magnitude_comparator #(.WIDTH(8), .DIGIT(2)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 1), .in_ready(ir_b),
        .x(xs), .y(ys), .signed_mode(sm), .res_valid(rv_b), .res_ready(res_ready),
        .gt(gt_b), .eq(eq_b), .lt(lt_b), .digits(dg_b)
    );

    serial_magnitude_comparator #(.WIDTH(2), .DIGIT(1)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 2), .in_ready(ir_c),
        .x(xs[1:0]), .y(ys[1:0]), .signed_mode(sm), .res_valid(rv_c), .res_ready(res_ready),
        .gt(gt_c), .eq(eq_c), .lt(lt_c), .digits(dg_c)
    );

    always_comb begin
        case (sel)
            1: begin
                cur_ir = ir_b; cur_rv = rv_b; cur_f = {gt_b, eq_b, lt_b}; cur_dg = {1'b0, dg_b};
            end
            2: begin
                cur_ir = ir_c; cur_rv = rv_c; cur_f = {gt_c, eq_c, lt_c}; cur_dg = {2'b00, dg_c};
            end
            default: begin
                cur_ir = ir_a; cur_rv = rv_a; cur_f = {gt_a, eq_a, lt_a}; cur_dg = dg_a;
            end
        endcase
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Integer golden model: signed values via sign extension, digit count
    // from the first differing digit of the raw operands.
    function automatic void model(input int s, input logic [7:0] xv, input logic [7:0] yv,
                                  input logic m, output logic [2:0] f, output int dg);
        int w  = (s == 2) ? 2 : 8;
        int d  = (s == 1) ? 2 : 1;
        int n  = w / d;
        int xu = int'(xv) & ((1 << w) - 1);
        int yu = int'(yv) & ((1 << w) - 1);
        int xi = xu;
        int yi = yu;
        if (m && ((xu >> (w - 1)) & 1) == 1) xi = xu - (1 << w);
        if (m && ((yu >> (w - 1)) & 1) == 1) yi = yu - (1 << w);
        dg = n;
        for (int i = 0; i < n; i++) begin
            if (((xu >> (w - (i + 1) * d)) & ((1 << d) - 1)) !=
                ((yu >> (w - (i + 1) * d)) & ((1 << d) - 1))) begin
                dg = i + 1;
                break;
            end
        end
        f = (xi > yi) ? 3'b100 : (xi == yi) ? 3'b010 : 3'b001;
    endfunction

    task automatic wait_ready(input string name, output bit ok);
        int t = 0;
        while (!cur_ir && t < 20) begin
            @(posedge clk); #1; t++;
        end
        ok = cur_ir;
        if (!ok) check({name, "_ready_timeout"}, 0, 1);
    endtask

    task automatic accept(input logic [7:0] xv, input logic [7:0] yv, input logic m,
                          input logic [2:0] ef, input int ed);
        exp_t e;
        xs = xv; ys = yv; sm = m; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        e.flags = ef; e.digits = ed; e.lat = ed;
        sb.push_back(e);
    endtask

    task automatic wait_result(input string name, output int lat);
        lat = 0;
        while (!cur_rv && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic check_result(input string name, input int lat);
        exp_t e;
        if (sb.size() == 0) begin
            check({name, "_sb_empty"}, 0, 1);
            return;
        end
        e = sb.pop_front();
        check({name, "_res_valid"}, int'(cur_rv), 1);
        check({name, "_latency"}, lat, e.lat);
        check({name, "_flags"}, int'(cur_f), int'(e.flags));
        check({name, "_digits"}, int'(cur_dg), e.digits);
    endtask

    task automatic handshake(input string name);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check({name, "_post_rv"}, int'(cur_rv), 0);
        check({name, "_post_flags"}, int'(cur_f), 0);
        check({name, "_post_ready"}, int'(cur_ir), 1);
    endtask

    task automatic do_cmp(input string name, input int s, input logic [7:0] xv,
                          input logic [7:0] yv, input logic m,
                          input logic [2:0] ef, input int ed);
        bit ok;
        int lat;
        sel = s;
        #1;
        wait_ready(name, ok);
        if (!ok) return;
        accept(xv, yv, m, ef, ed);
        wait_result(name, lat);
        check_result(name, lat);
        handshake(name);
    endtask

    initial begin
        bit         ok;
        int         lat;
        logic [2:0] ef;
        int         ed;
        logic [2:0] held_f;
        logic [3:0] held_dg;

        vecs[0] = '{0, 8'hA5, 8'hA4, 1'b0, 3'b100, 8};
        vecs[1] = '{0, 8'h80, 8'h7F, 1'b0, 3'b100, 1};
        vecs[2] = '{0, 8'h80, 8'h7F, 1'b1, 3'b001, 1};
        vecs[3] = '{0, 8'hFF, 8'h00, 1'b1, 3'b001, 1};
        vecs[4] = '{0, 8'h7F, 8'h80, 1'b1, 3'b100, 1};
        vecs[5] = '{0, 8'h00, 8'h00, 1'b1, 3'b010, 8};
        vecs[6] = '{1, 8'h3C, 8'h3C, 1'b0, 3'b010, 4};
        vecs[7] = '{1, 8'h12, 8'h13, 1'b0, 3'b001, 4};
        vecs[8] = '{1, 8'hC0, 8'h40, 1'b1, 3'b001, 1};
        vecs[9] = '{1, 8'h21, 8'h2F, 1'b0, 3'b001, 3};

        // Reset values, and in_ready one cycle after release.
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", int'(ir_a), 0);
        check("rst_res_valid", int'(rv_a), 0);
        check("rst_flags", int'({gt_a, eq_a, lt_a}), 0);
        check("rst_digits", int'(dg_a), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rel_in_ready", int'(ir_a), 1);

        foreach (vecs[i])
            do_cmp($sformatf("vec%0d", i), vecs[i].sel, vecs[i].x, vecs[i].y,
                   vecs[i].sm, vecs[i].flags, vecs[i].digits);

        for (int m = 0; m < 2; m++)
            for (int xv = 0; xv < 4; xv++)
                for (int yv = 0; yv < 4; yv++) begin
                    model(2, 8'(xv), 8'(yv), 1'(m), ef, ed);
                    do_cmp($sformatf("w2_m%0d_x%0d_y%0d", m, xv, yv), 2, 8'(xv), 8'(yv),
                           1'(m), ef, ed);
                end

        // Backpressure: result held for 5 cycles, busy in_valid ignored.
        sel = 0;
        #1;
        wait_ready("bp", ok);
        if (ok) begin
            accept(8'h55, 8'h50, 1'b0, 3'b100, 6);
            wait_result("bp", lat);
            check_result("bp", lat);
            held_f  = cur_f;
            held_dg = cur_dg;
            for (int c = 0; c < 5; c++) begin
                if (c == 2) begin
                    xs = 8'h01; ys = 8'h00; in_valid = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
                @(posedge clk); #1;
                check($sformatf("bp_hold%0d_flags", c), int'(cur_f), 3'b100);
                check($sformatf("bp_hold%0d_digits", c), int'(cur_dg), 6);
                check($sformatf("bp_hold%0d_rv", c), int'(cur_rv), 1);
                check($sformatf("bp_hold%0d_ready", c), int'(cur_ir), 0);
            end
            in_valid = 1'b0;
            check("bp_held_match", int'({held_f, held_dg}), int'({3'b100, 4'd6}));
            handshake("bp");
            for (int c = 0; c < 3; c++) begin
                @(posedge clk); #1;
                check($sformatf("bp_no_ghost%0d", c), int'(cur_rv), 0);
            end
        end

        // Reset two cycles into RUN aborts with no result.
        sel = 0;
        #1;
        wait_ready("rr", ok);
        if (ok) begin
            xs = 8'h00; ys = 8'h01; sm = 1'b0; in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            @(posedge clk); #1;
            check("rr_running_rv", int'(rv_a), 0);
            rst_n = 1'b0;
            #1;
            check("rr_rv", int'(rv_a), 0);
            check("rr_flags", int'({gt_a, eq_a, lt_a}), 0);
            check("rr_digits", int'(dg_a), 0);
            check("rr_in_ready", int'(ir_a), 0);
            for (int c = 0; c < 3; c++) begin
                @(posedge clk); #1;
                check($sformatf("rr_hold%0d_rv", c), int'(rv_a), 0);
            end
            rst_n = 1'b1;
            @(posedge clk); #1;
            check("rr_rel_ready", int'(ir_a), 1);
            for (int c = 0; c < 10; c++) begin
                @(posedge clk); #1;
                check($sformatf("rr_idle%0d_rv", c), int'(rv_a), 0);
            end
            do_cmp("rr_fresh", 0, 8'h00, 8'h01, 1'b0, 3'b001, 8);
        end

        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
